// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency-meter front end: edge-mode encoding
// and the helper that decides whether a level transition is reportable.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    // new_level is the level being entered, so 1 means a 0->1 transition.
    function automatic logic edge_qualifies(input edge_mode_e m, input logic new_level);
        logic hit;
        hit = 1'b0;
        case (m)
            MODE_RISE: hit = new_level;
            MODE_FALL: hit = ~new_level;
            MODE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One edge-detector channel: synchroniser, stability filter, mode-qualified
// edge pulse, sticky pending flag and saturating edge counter.
module edge_det_channel
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             level,
    output logic             detect,
    output logic             pending,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int               FC_W    = $clog2(FILTER_LEN) + 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FC_W-1:0]        r_fc;
    logic                   r_level;
    logic                   r_detect;
    logic                   r_pending;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_s;
    logic                   w_accept;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_accept = (w_s != r_level) && (r_fc == FC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
        end
    end

    // fc counts consecutive cycles the synchronised input has disagreed with
    // level; any agreement restarts it, so a glitch can never be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fc     <= '0;
            r_level  <= 1'b0;
            r_detect <= 1'b0;
        end else begin
            r_detect <= 1'b0;
            if (w_s == r_level) begin
                r_fc <= '0;
            end else if (w_accept) begin
                r_level  <= w_s;
                r_fc     <= '0;
                r_detect <= edge_qualifies(edge_mode_e'(mode), w_s);
            end else begin
                r_fc <= r_fc + FC_W'(1);
            end
        end
    end

    // Pending and the counter react to the registered pulse, so a clear that
    // arrives while detect is visible still loses to that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (r_detect) begin
                r_pending <= 1'b1;
            end else if (clr) begin
                r_pending <= 1'b0;
            end

            if (clr) begin
                r_cnt <= r_detect ? CNT_W'(1) : '0;
            end else if (r_detect && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level    = r_level;
    assign detect   = r_detect;
    assign pending  = r_pending;
    assign edge_cnt = r_cnt;

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel edge detector for the frequency-meter front end: one independent
// edge_det_channel per input plus the combined pending flag.
module multi_edge_detector
    import freq_meter_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       sig_in,
    input  logic [2*N_CH-1:0]     mode,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH-1:0]       level,
    output logic [N_CH-1:0]       detect,
    output logic [N_CH-1:0]       pending,
    output logic [N_CH*CNT_W-1:0] edge_cnt,
    output logic                  any_pend
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            edge_det_channel #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILTER_LEN  (FILTER_LEN),
                .CNT_W       (CNT_W)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .sig_in   (sig_in[gi]),
                .mode     (mode[2*gi +: 2]),
                .clr      (clr[gi]),
                .level    (level[gi]),
                .detect   (detect[gi]),
                .pending  (pending[gi]),
                .edge_cnt (edge_cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign any_pend = |pending;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: directed scenarios plus random traffic, all
// checked every cycle against a window-based behavioural model.
module tb_multi_edge_detector;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int F  = 4;
    localparam int W  = 16;
    localparam int WS = 3;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    sig_in;
    logic [2*N-1:0]  mode;
    logic [N-1:0]    clr;

    logic [N-1:0]    level,   detect,   pending;
    logic [N*W-1:0]  edge_cnt;
    logic            any_pend;
    logic [N-1:0]    level_s, detect_s, pending_s;
    logic [N*WS-1:0] edge_cnt_s;
    logic            any_pend_s;

    int n_cmp = 0;
    int n_err = 0;

    multi_edge_detector #(.N_CH(N), .SYNC_STAGES(S), .FILTER_LEN(F), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .mode(mode), .clr(clr),
        .level(level), .detect(detect), .pending(pending),
        .edge_cnt(edge_cnt), .any_pend(any_pend)
    );

    multi_edge_detector #(.N_CH(N), .SYNC_STAGES(S), .FILTER_LEN(F), .CNT_W(WS)) dut_sat (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .mode(mode), .clr(clr),
        .level(level_s), .detect(detect_s), .pending(pending_s),
        .edge_cnt(edge_cnt_s), .any_pend(any_pend_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [63:0] clamp(input int v, input int mx);
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    // Reference model: level flips once the synchronised input (sig_in seen
    // S edges earlier) has shown the opposite value on the last F edges.
    logic [N-1:0] raw_q[$];
    logic [N-1:0] s_q[$];
    logic [N-1:0] m_lvl, m_det, m_pend;
    int           m_total[N];

    always @(posedge clk or negedge rst_n) begin : model
        logic [N-1:0] s_now;
        bit           flip;
        if (!rst_n) begin
            raw_q.delete();
            s_q.delete();
            m_lvl  = '0;
            m_det  = '0;
            m_pend = '0;
            for (int c = 0; c < N; c++) m_total[c] = 0;
        end else begin
            raw_q.push_back(sig_in);
            if (raw_q.size() > 16) void'(raw_q.pop_front());
            s_now = (raw_q.size() > S) ? raw_q[raw_q.size()-1-S] : '0;
            s_q.push_back(s_now);
            if (s_q.size() > 16) void'(s_q.pop_front());
            for (int c = 0; c < N; c++) begin
                if (clr[c]) m_total[c] = m_det[c] ? 1 : 0;
                else if (m_det[c]) m_total[c] = m_total[c] + 1;
                if (m_det[c]) m_pend[c] = 1'b1;
                else if (clr[c]) m_pend[c] = 1'b0;

                flip = (s_q.size() >= F);
                for (int k = 0; k < F; k++)
                    if (flip && (s_q[s_q.size()-1-k][c] == m_lvl[c])) flip = 0;
                if (flip) begin
                    m_lvl[c] = ~m_lvl[c];
                    m_det[c] = m_lvl[c] ? mode[2*c] : mode[2*c+1];
                end else begin
                    m_det[c] = 1'b0;
                end
            end
        end
    end

    int obs_pulses[N];
    initial for (int c = 0; c < N; c++) obs_pulses[c] = 0;

    always @(negedge clk) begin : scoreboard
        for (int c = 0; c < N; c++) if (detect[c] === 1'b1) obs_pulses[c]++;
        check("level",      level,      m_lvl);
        check("detect",     detect,     m_det);
        check("pending",    pending,    m_pend);
        check("any_pend",   any_pend,   |m_pend);
        check("level_s",    level_s,    m_lvl);
        check("detect_s",   detect_s,   m_det);
        check("pending_s",  pending_s,  m_pend);
        check("any_pend_s", any_pend_s, |m_pend);
        for (int c = 0; c < N; c++) begin
            check($sformatf("cnt16[%0d]", c), edge_cnt[c*W +: W],    clamp(m_total[c], (1 << W) - 1));
            check($sformatf("cnt3[%0d]", c),  edge_cnt_s[c*WS +: WS], clamp(m_total[c], (1 << WS) - 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_all();
        clr = '1;
        tick(1);
        clr = '0;
    endtask

    task automatic drive_pulses(input int ch, input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            sig_in[ch] = 1'b1;
            tick(hi);
            sig_in[ch] = 1'b0;
            tick(lo);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   level,      '0);
        check({tag, "_detect"},  detect,     '0);
        check({tag, "_pending"}, pending,    '0);
        check({tag, "_anyp"},    any_pend,   '0);
        check({tag, "_cnt"},     edge_cnt,   '0);
        check({tag, "_cnt_s"},   edge_cnt_s, '0);
    endtask

    int  lat;
    int  p0;
    int  pb[N];
    bit  found;
    int  hold[N];

    initial begin
        rst_n  = 1'b0;
        sig_in = '0;
        mode   = '0;
        clr    = '0;

        // Reset holds everything at zero whatever the inputs do.
        for (int i = 0; i < 6; i++) begin
            sig_in = N'($urandom_range(0, (1 << N) - 1));
            tick(1);
            check_all_zero("rst_hold");
        end
        sig_in = N'(1);
        mode   = 8'b00_00_00_01;
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (detect[0] === 1'b1 && lat == 0) lat = i;
        end
        check("rst_latency", lat, S + F);
        check("rst_cnt0", edge_cnt[0 +: W], 1);
        check("rst_pend0", pending[0], 1);

        // Glitch shorter than the filter is ignored; one that holds is accepted.
        sig_in = '0;
        clear_all();
        tick(12);
        p0 = obs_pulses[0];
        sig_in[0] = 1'b1;
        tick(F - 1);
        sig_in[0] = 1'b0;
        tick(12);
        check("glitch_pulses", obs_pulses[0] - p0, 0);
        check("glitch_level", level[0], 0);
        sig_in[0] = 1'b1;
        tick(F);
        tick(12);
        check("hold_pulses", obs_pulses[0] - p0, 1);
        check("hold_level", level[0], 1);
        sig_in[0] = 1'b0;
        tick(12);

        // Square wave on all channels, one per mode.
        mode = 8'b11_10_01_00;
        clear_all();
        tick(4);
        for (int c = 0; c < N; c++) pb[c] = obs_pulses[c];
        for (int p = 0; p < 10; p++) begin
            sig_in = '1;
            tick(10);
            sig_in = '0;
            tick(10);
        end
        tick(12);
        check("mode_off_cnt",  edge_cnt[0*W +: W], 0);
        check("mode_rise_cnt", edge_cnt[1*W +: W], 10);
        check("mode_fall_cnt", edge_cnt[2*W +: W], 10);
        check("mode_both_cnt", edge_cnt[3*W +: W], 20);
        check("mode_off_p",    obs_pulses[0] - pb[0], 0);
        check("mode_rise_p",   obs_pulses[1] - pb[1], 10);
        check("mode_fall_p",   obs_pulses[2] - pb[2], 10);
        check("mode_both_p",   obs_pulses[3] - pb[3], 20);
        check("sat_off_cnt",   edge_cnt_s[0*WS +: WS], 0);
        check("sat_rise_cnt",  edge_cnt_s[1*WS +: WS], 7);
        check("sat_both_cnt",  edge_cnt_s[3*WS +: WS], 7);

        // Clear arriving in the same cycle as the detect pulse.
        mode = 8'b00_00_01_00;
        clear_all();
        tick(2);
        check("race_idle_anyp", any_pend, 0);
        sig_in[1] = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (detect[1] === 1'b1) found = 1;
        end
        check("race_found", found, 1);
        clr = 4'b0010;
        tick(1);
        check("race_pend", pending[1], 1);
        check("race_cnt", edge_cnt[1*W +: W], 1);
        tick(1);
        clr = '0;
        check("clr_pend", pending[1], 0);
        check("clr_cnt", edge_cnt[1*W +: W], 0);
        check("clr_anyp", any_pend, 0);
        sig_in[1] = 1'b0;
        tick(12);

        // Saturation of the narrow counter while the wide one keeps counting.
        clear_all();
        drive_pulses(1, 10, 8, 8);
        tick(4);
        check("sat_hold7", edge_cnt_s[1*WS +: WS], 7);
        check("sat_wide10", edge_cnt[1*W +: W], 10);

        // Reset in the middle of filtering and counting.
        mode = 8'b00_00_00_01;
        clear_all();
        drive_pulses(0, 5, 8, 8);
        check("pre_rst_cnt", edge_cnt[0 +: W], 5);
        sig_in[0] = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        sig_in = '0;
        tick(3);
        rst_n = 1'b1;
        p0 = obs_pulses[0];
        tick(12);
        check("midrst_nopulse", obs_pulses[0] - p0, 0);
        check("midrst_level", level[0], 0);
        check("midrst_cnt", edge_cnt[0 +: W], 0);

        // Random traffic with glitches, mode changes and clears.
        mode = 8'($urandom_range(0, 255));
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    sig_in[c] = ~sig_in[c];
                    hold[c] = $urandom_range(1, 2 * F + 2);
                end else begin
                    hold[c]--;
                end
                clr[c] = ($urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom_range(0, 255));
            tick(1);
        end
        clr = '0;
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
